// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Sequencing and hazard controller for the 5-stage pipeline.
// A run/step/drain/halt FSM, commanded by the debug unit, decides when the
// pipeline may advance (o_pipe_en). While it advances, combinational hazard
// logic resolves load-use stalls against ID_EX and flushes on a taken branch
// resolved in MEM. A saturating counter records the number of cycles in
// which the pipeline advanced.
//
// Ports:
//   i_clock, i_reset_n     clock, asynchronous active-low reset
//   i_run, i_step          debug commands (continuous run / single step)
//   i_ID_rs, i_ID_rt       source registers of the instruction in ID
//   i_EX_rt                destination (rt) of the instruction in ID_EX
//   i_EX_mem_read          ID_EX instruction is a load
//   i_MEM_branch_taken     branch in MEM resolved taken
//   i_ID_halt              instruction in ID is HALT
//   o_pipe_en              global enable for stage registers and PC
//   o_pc_write             PC load enable
//   o_IF_ID_write          IF_ID load enable
//   o_IF_ID_flush          IF_ID loads NOP
//   o_ID_EX_bubble         ID_EX control fields load zero
//   o_EX_MEM_flush         EX_MEM control fields load zero
//   o_halted               program finished (registered)
//   o_cycle_count          number of cycles with o_pipe_en=1 (saturating)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int NB_REG       = 5,
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_run,
  input  logic              i_step,
  input  logic [NB_REG-1:0] i_ID_rs,
  input  logic [NB_REG-1:0] i_ID_rt,
  input  logic [NB_REG-1:0] i_EX_rt,
  input  logic              i_EX_mem_read,
  input  logic              i_MEM_branch_taken,
  input  logic              i_ID_halt,
  output logic              o_pipe_en,
  output logic              o_pc_write,
  output logic              o_IF_ID_write,
  output logic              o_IF_ID_flush,
  output logic              o_ID_EX_bubble,
  output logic              o_EX_MEM_flush,
  output logic              o_halted,
  output logic [NB_CNT-1:0] o_cycle_count
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [DCW-1:0]    drain_q, drain_d;
  logic              halted_q, halted_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  logic load_use;
  logic branch;
  logic halt_accept;
  logic pipe_en;

  // Hazard detection, independent of FSM state; gated by pipe_en below.
  always_comb begin
    load_use    = i_EX_mem_read && (i_EX_rt != '0) &&
                  ((i_EX_rt == i_ID_rs) || (i_EX_rt == i_ID_rt));
    branch      = i_MEM_branch_taken;
    // A HALT that is stalled or sits in a taken-branch shadow is not taken.
    halt_accept = i_ID_halt && !load_use && !branch;
  end

  // State register and datapath registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      drain_q  <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_run)       state_d = S_RUN;
        else if (i_step) state_d = S_STEP;
      end
      S_RUN: begin
        if (halt_accept) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (!i_run) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (halt_accept) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_HALTED;
        else               drain_d = drain_q - 1'b1;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Halted flag and saturating advance counter
  always_comb begin
    halted_d = (state_d == S_HALTED);
    cnt_d    = cnt_q;
    if (pipe_en && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Output logic: Moore enable from state, Mealy hazard controls
  always_comb begin
    pipe_en        = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
    o_pc_write     = 1'b0;
    o_IF_ID_write  = 1'b0;
    o_IF_ID_flush  = 1'b0;
    o_ID_EX_bubble = 1'b0;
    o_EX_MEM_flush = 1'b0;
    if (pipe_en) begin
      if (branch) begin
        // Flush path: IF_ID must be written so that it captures the NOP.
        o_pc_write     = 1'b1;
        o_IF_ID_write  = 1'b1;
        o_IF_ID_flush  = 1'b1;
        o_ID_EX_bubble = 1'b1;
        o_EX_MEM_flush = 1'b1;
      end else if (load_use) begin
        o_ID_EX_bubble = 1'b1;
      end else begin
        o_pc_write     = 1'b1;
        o_IF_ID_write  = 1'b1;
      end
      // While draining, fetch is frozen and only NOPs enter IF_ID so the
      // instructions already past ID retire.
      if (state_q == S_DRAIN) begin
        o_pc_write    = 1'b0;
        o_IF_ID_flush = 1'b1;
      end
    end
  end

  assign o_pipe_en     = pipe_en;
  assign o_halted      = halted_q;
  assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run, step, mr, br, halt;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        pipe_en, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, halted;
  logic [31:0] cycle_count;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(
    .NB_REG(5),
    .NB_CNT(32),
    .DRAIN_CYCLES(4)
  ) dut (
    .i_clock           (clk),
    .i_reset_n         (rst_n),
    .i_run             (run),
    .i_step            (step),
    .i_ID_rs           (id_rs),
    .i_ID_rt           (id_rt),
    .i_EX_rt           (ex_rt),
    .i_EX_mem_read     (mr),
    .i_MEM_branch_taken(br),
    .i_ID_halt         (halt),
    .o_pipe_en         (pipe_en),
    .o_pc_write        (pc_write),
    .o_IF_ID_write     (ifid_write),
    .o_IF_ID_flush     (ifid_flush),
    .o_ID_EX_bubble    (idex_bubble),
    .o_EX_MEM_flush    (exmem_flush),
    .o_halted          (halted),
    .o_cycle_count     (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output bits: {pipe_en, pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_flush, halted}
  localparam logic [6:0] O_OFF   = 7'b0000000;
  localparam logic [6:0] O_NORM  = 7'b1110000;
  localparam logic [6:0] O_STALL = 7'b1000100;
  localparam logic [6:0] O_BR    = 7'b1111110;
  localparam logic [6:0] O_DRAIN = 7'b1011000;
  localparam logic [6:0] O_HALT  = 7'b0000001;

  typedef struct {
    logic        run, step, mr;
    logic [4:0]  ex_rt, rs, rt;
    logic        br, halt;
    logic [6:0]  exp_o;
    int unsigned exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] outs();
    return {pipe_en, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, halted};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic m, input logic [4:0] er,
                     input logic [4:0] rs, input logic [4:0] rt, input logic b, input logic h,
                     input logic [6:0] eo, input int unsigned ec);
    vec_t v;
    v.run = r; v.step = s; v.mr = m; v.ex_rt = er; v.rs = rs; v.rt = rt;
    v.br = b; v.halt = h; v.exp_o = eo; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic clear_inputs();
    run = 0; step = 0; mr = 0; br = 0; halt = 0;
    id_rs = '0; id_rt = '0; ex_rt = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset outs", 32'(outs()), 32'(O_OFF));
    chk("reset count", cycle_count, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    //  run step mr ex_rt rs rt br halt  expected  count-before-edge
    add(0, 0, 0, 0, 0, 0, 0, 0, O_OFF,   0);   // idle
    add(0, 1, 0, 0, 0, 0, 0, 0, O_OFF,   0);   // step #1 sampled
    add(0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  0);   // STEP cycle
    add(0, 1, 0, 0, 0, 0, 0, 0, O_OFF,   1);   // step #2
    add(0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  1);
    add(0, 1, 0, 0, 0, 0, 0, 0, O_OFF,   2);   // step #3
    add(0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  2);
    add(0, 0, 0, 0, 0, 0, 0, 0, O_OFF,   3);   // back in IDLE, 3 cycles counted
    add(1, 0, 0, 0, 0, 0, 0, 0, O_OFF,   3);   // run sampled
    add(1, 0, 1, 5, 5, 0, 0, 0, O_STALL, 3);   // load-use on rs
    add(1, 0, 1, 0, 0, 0, 0, 0, O_NORM,  4);   // rt=0 never stalls
    add(1, 0, 1, 5, 3, 5, 0, 0, O_STALL, 5);   // load-use on rt
    add(1, 0, 1, 5, 5, 0, 1, 0, O_BR,    6);   // branch wins over stall
    add(1, 0, 0, 0, 0, 0, 1, 1, O_BR,    7);   // halt in branch shadow ignored
    add(1, 0, 1, 5, 5, 0, 0, 1, O_STALL, 8);   // stalled halt ignored
    add(0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  9);   // pause: last RUN cycle
    add(1, 1, 0, 0, 0, 0, 0, 0, O_OFF,  10);   // run+step -> RUN
    add(1, 1, 0, 0, 0, 0, 0, 0, O_NORM, 10);   // step ignored in RUN
    add(1, 0, 0, 0, 0, 0, 0, 1, O_NORM, 11);   // halt accepted
    add(0, 0, 0, 0, 0, 0, 0, 0, O_DRAIN,12);   // drain 1 (run ignored)
    add(0, 1, 0, 0, 0, 0, 0, 0, O_DRAIN,13);   // drain 2
    add(1, 0, 0, 0, 0, 0, 0, 0, O_DRAIN,14);   // drain 3
    add(0, 0, 0, 0, 0, 0, 0, 0, O_DRAIN,15);   // drain 4
    add(1, 0, 0, 0, 0, 0, 0, 0, O_HALT, 16);   // halted, run ignored
    add(0, 1, 0, 0, 0, 0, 0, 0, O_HALT, 16);
    add(0, 0, 0, 0, 0, 0, 0, 0, O_HALT, 16);

    foreach (vecs[i]) begin
      @(negedge clk);
      run = vecs[i].run; step = vecs[i].step; mr = vecs[i].mr;
      ex_rt = vecs[i].ex_rt; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      br = vecs[i].br; halt = vecs[i].halt;
      #1;
      chk($sformatf("vec%0d outs", i), 32'(outs()), 32'(vecs[i].exp_o));
      chk($sformatf("vec%0d count", i), cycle_count, vecs[i].exp_cnt);
    end

    // Asynchronous reset in the middle of DRAIN
    @(negedge clk) begin clear_inputs(); rst_n = 1'b0; end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) run = 1;
    @(negedge clk) halt = 1;
    @(negedge clk) begin run = 0; halt = 0; end
    #1;
    chk("pre-reset drain outs", 32'(outs()), 32'(O_DRAIN));
    chk("pre-reset drain count", cycle_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outs", 32'(outs()), 32'(O_OFF));
    chk("async reset count", cycle_count, 0);

    // Step after release; a halt accepted in STEP enters DRAIN
    @(negedge clk) begin rst_n = 1'b1; step = 1; end
    @(negedge clk) begin step = 0; halt = 1; end
    #1;
    chk("step after reset outs", 32'(outs()), 32'(O_NORM));
    chk("step after reset count", cycle_count, 0);
    @(negedge clk) halt = 0;
    #1;
    chk("step halt drain outs", 32'(outs()), 32'(O_DRAIN));
    chk("step halt drain count", cycle_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
